// File: rtl/osc_mixer_pkg.sv
// Shared definitions for the oscillator mixer: FSM state type, accumulator
// sizing and offset-binary midpoint helper. Used by osc_mixer and, when
// OSC_MIXER_NORMALIZE_EN is defined, by osc_mix_divider's instantiation.
package osc_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUT
    } mixer_state_t;

    localparam int DEFAULT_NUM_OSCILLATORS = 4;
    localparam int DEFAULT_SAMPLE_WIDTH    = 16;

    // Signed accumulator width: one sign bit plus headroom for summing every lane.
    function automatic int acc_width_of(input int sample_width, input int num_osc);
        return sample_width + $clog2(num_osc) + 1;
    endfunction

    // Offset-binary midpoint; adding or subtracting it is the same as flipping the MSB.
    function automatic int midpoint_of(input int sample_width);
        return 1 << (sample_width - 1);
    endfunction

    localparam int ACC_WIDTH = acc_width_of(DEFAULT_SAMPLE_WIDTH, DEFAULT_NUM_OSCILLATORS);

endpackage

// File: rtl/osc_mix_divider.sv
// Unsigned sequential restoring divider with a start/done handshake.
// The first quotient bit is resolved in the same cycle that start_in is
// sampled, so done_out is high DIVIDEND_W cycles after start_in. It is
// only instantiated when OSC_MIXER_NORMALIZE_EN is defined.
module osc_mix_divider #(
    parameter int DIVIDEND_W = 19,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [DIVIDEND_W-1:0] dividend_in,
    input  logic [DIVISOR_W-1:0]  divisor_in,
    output logic [DIVIDEND_W-1:0] quotient_out,
    output logic                  done_out
);

    localparam int STEP_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  div_q;
    logic [STEP_W-1:0]     steps_q;
    logic                  busy_q;

    logic [DIVIDEND_W-1:0] src_quo;
    logic [DIVISOR_W-1:0]  src_rem;
    logic [DIVISOR_W-1:0]  src_div;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quo_next;
    logic                  quo_bit;

    // One restoring step: shift the next dividend bit into the remainder and subtract if it fits.
    always_comb begin
        src_quo  = start_in ? dividend_in : quo_q;
        src_rem  = start_in ? '0 : rem_q;
        src_div  = start_in ? divisor_in : div_q;
        trial    = {src_rem, src_quo[DIVIDEND_W-1]};
        quo_bit  = 1'b0;
        rem_next = DIVISOR_W'(trial);
        if (trial >= {1'b0, src_div}) begin
            quo_bit  = 1'b1;
            rem_next = DIVISOR_W'(trial - {1'b0, src_div});
        end
        quo_next = {src_quo[DIVIDEND_W-2:0], quo_bit};
    end

    // Iteration register: load on start, step until all dividend bits are consumed.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
        end else if (start_in) begin
            quo_q   <= quo_next;
            rem_q   <= rem_next;
            div_q   <= divisor_in;
            steps_q <= STEP_W'(DIVIDEND_W - 1);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            if (steps_q != '0) begin
                quo_q   <= quo_next;
                rem_q   <= rem_next;
                steps_q <= steps_q - STEP_W'(1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_out     = busy_q && (steps_q == '0);
    assign quotient_out = quo_q;

endmodule

// File: rtl/osc_mixer.sv
// Oscillator mixer: once per sample_tick_in, visits one lane per clock,
// sums the enabled lanes as signed samples, scales, saturates and presents
// an offset-binary result with a one-cycle valid pulse.
// Optional feature macro OSC_MIXER_NORMALIZE_EN: divide by the number of
// active lanes instead of shifting by log2 of the lane count.
module osc_mixer
    import osc_mixer_pkg::*;
#(
    parameter int NUM_OSCILLATORS = DEFAULT_NUM_OSCILLATORS,
    parameter int SAMPLE_WIDTH    = DEFAULT_SAMPLE_WIDTH
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          sample_tick_in,
    input  logic [NUM_OSCILLATORS-1:0]                    osc_is_on_in,
    input  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]  osc_data_in,
    output logic [SAMPLE_WIDTH-1:0]                       mix_data_out,
    output logic                                          mix_valid_out,
    output logic [$clog2(NUM_OSCILLATORS+1)-1:0]          active_cnt_out,
    output logic                                          busy_out,
    output logic                                          overrun_out
);

    localparam int ACC_W  = acc_width_of(SAMPLE_WIDTH, NUM_OSCILLATORS);
    localparam int CNT_W  = $clog2(NUM_OSCILLATORS + 1);
    localparam int LANE_W = $clog2(NUM_OSCILLATORS);
    localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(NUM_OSCILLATORS - 1);
    localparam logic [SAMPLE_WIDTH-1:0] MIDPOINT  = SAMPLE_WIDTH'(midpoint_of(SAMPLE_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(midpoint_of(SAMPLE_WIDTH) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = -SAT_MAX - ACC_W'(1);

    mixer_state_t state, state_next;

    logic [NUM_OSCILLATORS-1:0] on_q;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           count;
    logic [LANE_W-1:0]          lane;
    logic [SAMPLE_WIDTH-1:0]    lane_data;
    logic signed [ACC_W-1:0]    lane_ext;
    logic signed [ACC_W-1:0]    scaled;
    logic [SAMPLE_WIDTH-1:0]    result_sat;
    logic                       scale_done;

    // Offset-binary to signed: flip the MSB, then sign-extend to the accumulator width.
    assign lane_data = osc_data_in[lane];
    assign lane_ext  = {{(ACC_W-SAMPLE_WIDTH){~lane_data[SAMPLE_WIDTH-1]}},
                        ~lane_data[SAMPLE_WIDTH-1], lane_data[SAMPLE_WIDTH-2:0]};

`ifdef OSC_MIXER_NORMALIZE_EN
    logic                 acc_neg;
    logic [ACC_W-1:0]     acc_mag;
    logic [ACC_W-1:0]     quotient;
    logic                 div_start;
    logic                 div_done;
    logic                 scale_first;

    assign acc_neg   = acc[ACC_W-1];
    assign acc_mag   = acc_neg ? -acc : acc;
    assign div_start = (state == SCALE) && scale_first;

    osc_mix_divider #(
        .DIVIDEND_W (ACC_W),
        .DIVISOR_W  (CNT_W)
    ) u_divider (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (div_start),
        .dividend_in  (acc_mag),
        .divisor_in   (count),
        .quotient_out (quotient),
        .done_out     (div_done)
    );

    // Flags the first SCALE cycle so the divider is started exactly once per mix.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            scale_first <= 1'b0;
        end else begin
            scale_first <= (state == ACCUM) && (lane == LAST_LANE);
        end
    end

    // Divide the magnitude by the active lane count and restore the sign; no lanes gives zero.
    always_comb begin
        scaled     = '0;
        scale_done = div_done;
        if (count != '0) begin
            scaled = acc_neg ? -$signed(quotient) : $signed(quotient);
        end
    end
`else
    localparam int SHIFT = $clog2(NUM_OSCILLATORS);

    // Fixed attenuation by the lane count rounded up to a power of two; completes in one cycle.
    always_comb begin
        scaled     = acc >>> SHIFT;
        scale_done = 1'b1;
    end
`endif

    // Clamp the scaled value to the signed sample range.
    always_comb begin
        result_sat = scaled[SAMPLE_WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            result_sat = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            result_sat = SAT_MIN[SAMPLE_WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: IDLE -> ACCUM -> SCALE -> OUT -> IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (sample_tick_in) state_next = ACCUM;
            ACCUM:   if (lane == LAST_LANE) state_next = SCALE;
            SCALE:   if (scale_done) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: valid is the single OUT cycle, busy covers every non-IDLE cycle.
    always_comb begin
        busy_out      = (state != IDLE);
        mix_valid_out = (state == OUT);
    end

    // Datapath: snapshot enables, accumulate one lane per cycle, register the result entering OUT.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            on_q           <= '0;
            acc            <= '0;
            count          <= '0;
            lane           <= '0;
            mix_data_out   <= MIDPOINT;
            active_cnt_out <= '0;
            overrun_out    <= 1'b0;
        end else begin
            if (sample_tick_in && (state != IDLE)) begin
                overrun_out <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (sample_tick_in) begin
                        on_q  <= osc_is_on_in;
                        acc   <= '0;
                        count <= '0;
                        lane  <= '0;
                    end
                end
                ACCUM: begin
                    if (on_q[lane]) begin
                        acc   <= acc + lane_ext;
                        count <= count + CNT_W'(1);
                    end
                    lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
                end
                SCALE: begin
                    if (scale_done) begin
                        mix_data_out   <= {~result_sat[SAMPLE_WIDTH-1], result_sat[SAMPLE_WIDTH-2:0]};
                        active_cnt_out <= count;
                    end
                end
                OUT: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_mixer.sv
// Scoreboard testbench for osc_mixer (4 lanes, 16-bit samples). Expected
// results are queued when a tick is issued; a monitor pops and compares
// data, active count and arrival cycle on every valid pulse.
module tb_osc_mixer;

    localparam int N = 4;
    localparam int S = 16;
`ifdef OSC_MIXER_NORMALIZE_EN
    localparam int LAT = N + (S + 2 + 1) + 2;
`else
    localparam int LAT = N + 2;
`endif

    typedef struct {
        logic [S-1:0] data;
        int           cnt;
        int           due;
        string        name;
    } exp_t;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                sample_tick_in;
    logic [N-1:0]        osc_is_on_in;
    logic [N-1:0][S-1:0] osc_data_in;
    logic [S-1:0]        mix_data_out;
    logic                mix_valid_out;
    logic [2:0]          active_cnt_out;
    logic                busy_out;
    logic                overrun_out;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    osc_mixer #(
        .NUM_OSCILLATORS (N),
        .SAMPLE_WIDTH    (S)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_tick_in (sample_tick_in),
        .osc_is_on_in   (osc_is_on_in),
        .osc_data_in    (osc_data_in),
        .mix_data_out   (mix_data_out),
        .mix_valid_out  (mix_valid_out),
        .active_cnt_out (active_cnt_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [N-1:0][S-1:0] pack4(input logic [S-1:0] d0, input logic [S-1:0] d1,
                                                  input logic [S-1:0] d2, input logic [S-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Issue one tick and queue the response it must produce.
    task automatic applyStimulus(input string name, input logic [N-1:0] on_v,
                                 input logic [N-1:0][S-1:0] data_v,
                                 input logic [S-1:0] exp_data, input int exp_cnt);
        exp_t e;
        @(posedge clk_in);
        #1;
        osc_is_on_in   = on_v;
        osc_data_in    = data_v;
        sample_tick_in = 1'b1;
        e.data = exp_data;
        e.cnt  = exp_cnt;
        e.due  = cyc + LAT;
        e.name = name;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b0;
    endtask

    // Tick that must not produce a result (dropped or aborted); lane data is left untouched.
    task automatic pulseTick(input logic [N-1:0] on_v);
        @(posedge clk_in);
        #1;
        osc_is_on_in   = on_v;
        sample_tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk_in);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (mix_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, "_data"}, int'(mix_data_out), int'(mon_e.data));
                checkOutput({mon_e.name, "_cnt"}, int'(active_cnt_out), mon_e.cnt);
                checkOutput({mon_e.name, "_latency"}, cyc, mon_e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        rst_in         = 1'b1;
        sample_tick_in = 1'b0;
        osc_is_on_in   = '0;
        osc_data_in    = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        checkOutput("reset_data", int'(mix_data_out), 'h8000);
        checkOutput("reset_valid", int'(mix_valid_out), 0);
        checkOutput("reset_cnt", int'(active_cnt_out), 0);
        checkOutput("reset_busy", int'(busy_out), 0);
        checkOutput("reset_overrun", int'(overrun_out), 0);

        $display("[TB] all lanes off");
        applyStimulus("all_off", 4'b0000, pack4(16'h1234, 16'hFFFF, 16'h0000, 16'hABCD), 16'h8000, 0);
        checkOutput("busy_during_mix", int'(busy_out), 1);
        waitDrain("all_off");
        checkOutput("idle_after_mix", int'(busy_out), 0);

        $display("[TB] all lanes on at full scale");
        applyStimulus("all_max", 4'b1111, pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF, 4);
        waitDrain("all_max");

        $display("[TB] single lane");
`ifdef OSC_MIXER_NORMALIZE_EN
        applyStimulus("lane0_only", 4'b0001, pack4(16'hC000, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hC000, 1);
`else
        applyStimulus("lane0_only", 4'b0001, pack4(16'hC000, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'h9000, 1);
`endif
        waitDrain("lane0_only");

        $display("[TB] two negative lanes");
`ifdef OSC_MIXER_NORMALIZE_EN
        applyStimulus("two_neg", 4'b0011, pack4(16'h0000, 16'h4000, 16'hFFFF, 16'hFFFF), 16'h2000, 2);
`else
        applyStimulus("two_neg", 4'b0011, pack4(16'h0000, 16'h4000, 16'hFFFF, 16'hFFFF), 16'h5000, 2);
`endif
        waitDrain("two_neg");

        $display("[TB] all lanes at full negative scale");
        applyStimulus("all_min", 4'b1111, pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h0000, 4);
        waitDrain("all_min");

        $display("[TB] cancelling lanes");
        applyStimulus("cancel", 4'b0101, pack4(16'h9000, 16'h1234, 16'h7000, 16'h1234), 16'h8000, 2);
        waitDrain("cancel");
        checkOutput("overrun_clear", int'(overrun_out), 0);

        $display("[TB] tick during OUT cycle is dropped");
`ifdef OSC_MIXER_NORMALIZE_EN
        applyStimulus("drop_at_out", 4'b0010, pack4(16'h1111, 16'hA000, 16'h2222, 16'h3333), 16'hA000, 1);
`else
        applyStimulus("drop_at_out", 4'b0010, pack4(16'h1111, 16'hA000, 16'h2222, 16'h3333), 16'h8800, 1);
`endif
        k = 0;
        while (mix_valid_out !== 1'b1 && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        if (mix_valid_out !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL drop_at_out_wait: got no valid expected valid within 100 cycles");
        end
        sample_tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b0;
        waitDrain("drop_at_out");
        repeat (LAT + 5) @(posedge clk_in);
        #1;
        checkOutput("overrun_at_out", int'(overrun_out), 1);

        $display("[TB] reset during ACCUM");
        pulseTick(4'b0001);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checkOutput("abort_data", int'(mix_data_out), 'h8000);
        checkOutput("abort_valid", int'(mix_valid_out), 0);
        checkOutput("abort_cnt", int'(active_cnt_out), 0);
        checkOutput("abort_busy", int'(busy_out), 0);
        checkOutput("abort_overrun", int'(overrun_out), 0);
        repeat (LAT + 5) @(posedge clk_in);
        #1;
        applyStimulus("after_abort", 4'b1111, pack4(16'h9000, 16'h9000, 16'h9000, 16'h9000), 16'h9000, 4);
        waitDrain("after_abort");

        $display("[TB] second tick two cycles after the first");
`ifdef OSC_MIXER_NORMALIZE_EN
        applyStimulus("overrun_first", 4'b0001, pack4(16'hC000, 16'h0000, 16'h0000, 16'h0000), 16'hC000, 1);
`else
        applyStimulus("overrun_first", 4'b0001, pack4(16'hC000, 16'h0000, 16'h0000, 16'h0000), 16'h9000, 1);
`endif
        pulseTick(4'b1111);
        checkOutput("overrun_set", int'(overrun_out), 1);
        waitDrain("overrun_first");
        repeat (LAT + 5) @(posedge clk_in);
        #1;
        checkOutput("overrun_sticky", int'(overrun_out), 1);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
